// File: rtl/uart_baud_gen_if.sv
// Configuration port bundle for uart_baud_gen: valid/ready transfer of the
// integer divisor and fractional trim, plus the reject pulse.
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_div;
    logic [FRAC_W-1:0] cfg_frac;
    logic              cfg_err;

    modport master (output cfg_valid, cfg_div, cfg_frac, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_div, cfg_frac, output cfg_ready, cfg_err);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud-tick generator: programmable divisor, separate TX/RX chains, RX re-phasing on rx_sync.
// Define UART_BAUD_FRAC_EN to enable the fractional-divisor accumulator and period stretch.
module uart_baud_gen #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int OVERSAMPLE      = 16,
    parameter int DIV_W           = 16,
    parameter int FRAC_W          = 4,
    parameter int RESET_DIV       = 27
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           active,
    uart_baud_gen_if.slave cfg,
    input  logic           rx_sync,
    output logic           tx_clk_en,
    output logic           rx_clk_en,
    output logic           rx_mid
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int CW   = DIV_W + 1;

    typedef logic [OS_W-1:0] os_t;
    typedef logic [CW-1:0]   cnt_t;

    localparam os_t OS_LAST = os_t'(OVERSAMPLE - 1);
    localparam os_t OS_MID  = os_t'(OVERSAMPLE / 2 - 1);

    if (OVERSAMPLE < 4 || OVERSAMPLE > 16 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
        CLOCK_FREQUENCY <= 0 || RESET_DIV < 2) begin : g_bad_param
        $error("uart_baud_gen: illegal parameter set");
    end

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] stg_div;
    logic [DIV_W-1:0] div_nxt;
    logic             pending;
    logic             cfg_err_q;
    logic             accept;
    logic             apply;

    cnt_t tx_cnt, tx_per, rx_cnt, rx_per;
    os_t  tx_os, rx_os;
    logic tx_tick, rx_hit, rx_tick;
    logic tx_carry, rx_carry;

    // Last count value of a period: D-1, or D when the chain's period is stretched.
    function automatic cnt_t period_last(input logic [DIV_W-1:0] d, input logic stretch);
        return {1'b0, d} + cnt_t'(stretch) - cnt_t'(1);
    endfunction

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q, stg_frac;
    logic [FRAC_W-1:0] tx_acc, rx_acc, tx_acc_nxt, rx_acc_nxt;

    assign {tx_carry, tx_acc_nxt} = {1'b0, tx_acc} + {1'b0, frac_q};
    assign {rx_carry, rx_acc_nxt} = {1'b0, rx_acc} + {1'b0, frac_q};
`else
    logic unused_frac;

    assign unused_frac = ^cfg.cfg_frac;
    assign tx_carry    = 1'b0;
    assign rx_carry    = 1'b0;
`endif

    assign cfg.cfg_ready = !pending;
    assign cfg.cfg_err   = cfg_err_q;
    assign accept        = cfg.cfg_valid && !pending;
    // Staged values land on a bit boundary, or straight away while idle.
    assign apply         = pending && (tx_clk_en || !active);
    assign div_nxt       = apply ? stg_div : div_q;

    assign tx_tick   = active && (tx_cnt == tx_per);
    assign rx_hit    = active && (rx_cnt == rx_per);
    assign rx_tick   = rx_hit && !rx_sync;
    assign tx_clk_en = tx_tick && (tx_os == OS_LAST);
    assign rx_clk_en = rx_tick;
    assign rx_mid    = rx_tick && (rx_os == OS_MID);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            div_q     <= DIV_W'(RESET_DIV);
            stg_div   <= '0;
            pending   <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            frac_q    <= '0;
            stg_frac  <= '0;
`endif
        end else begin
            cfg_err_q <= accept && (cfg.cfg_div < DIV_W'(2));
            if (accept && (cfg.cfg_div >= DIV_W'(2))) begin
                stg_div  <= cfg.cfg_div;
`ifdef UART_BAUD_FRAC_EN
                stg_frac <= cfg.cfg_frac;
`endif
                pending  <= 1'b1;
            end else if (apply) begin
                div_q   <= stg_div;
`ifdef UART_BAUD_FRAC_EN
                frac_q  <= stg_frac;
`endif
                pending <= 1'b0;
            end
        end
    end

    // TX chain: period length is latched at each tick so a new divisor starts on a clean period.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tx_cnt <= '0;
            tx_os  <= '0;
            tx_per <= period_last(DIV_W'(RESET_DIV), 1'b0);
`ifdef UART_BAUD_FRAC_EN
            tx_acc <= '0;
`endif
        end else if (!active) begin
            tx_cnt <= '0;
            tx_os  <= '0;
            tx_per <= period_last(div_nxt, 1'b0);
`ifdef UART_BAUD_FRAC_EN
            tx_acc <= '0;
`endif
        end else if (tx_tick) begin
            tx_cnt <= '0;
            tx_os  <= tx_os + os_t'(1);
            tx_per <= period_last(div_nxt, tx_carry);
`ifdef UART_BAUD_FRAC_EN
            tx_acc <= tx_acc_nxt;
`endif
        end else begin
            tx_cnt <= tx_cnt + cnt_t'(1);
        end
    end

    // RX chain: rx_sync restarts the bit so the mid strobe lands mid start-bit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_cnt <= '0;
            rx_os  <= '0;
            rx_per <= period_last(DIV_W'(RESET_DIV), 1'b0);
`ifdef UART_BAUD_FRAC_EN
            rx_acc <= '0;
`endif
        end else if (!active || rx_sync) begin
            rx_cnt <= '0;
            rx_os  <= '0;
            rx_per <= period_last(div_nxt, 1'b0);
`ifdef UART_BAUD_FRAC_EN
            rx_acc <= '0;
`endif
        end else if (rx_tick) begin
            rx_cnt <= '0;
            rx_os  <= rx_os + os_t'(1);
            rx_per <= period_last(div_nxt, rx_carry);
`ifdef UART_BAUD_FRAC_EN
            rx_acc <= rx_acc_nxt;
`endif
        end else begin
            rx_cnt <= rx_cnt + cnt_t'(1);
        end
    end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: expected pulse cycles are queued by the
// stimulus and consumed by a negedge monitor as the DUT emits pulses.
module tb_uart_baud_gen;
    localparam int OS    = 16;
    localparam int DIV_W = 16;
    localparam int FRAC_W = 4;
`ifdef UART_BAUD_FRAC_EN
    localparam int FRAC_ON = 1;
`else
    localparam int FRAC_ON = 0;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic active = 1'b0;
    logic rx_sync = 1'b0;
    logic tx_clk_en, rx_clk_en, rx_mid;

    int cyc = 0;
    int base = 0;
    int n_checks = 0;
    int n_errors = 0;
    int exp_rx[$];
    int exp_tx[$];
    int exp_mid[$];
    int obs_rx[$];

    uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) cfg_if();

    uart_baud_gen #(
        .CLOCK_FREQUENCY(50_000_000),
        .OVERSAMPLE(OS),
        .DIV_W(DIV_W),
        .FRAC_W(FRAC_W),
        .RESET_DIV(27)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .active(active),
        .cfg(cfg_if),
        .rx_sync(rx_sync),
        .tx_clk_en(tx_clk_en),
        .rx_clk_en(rx_clk_en),
        .rx_mid(rx_mid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int rel;
        rel = cyc - base;
        if (rx_clk_en) begin
            obs_rx.push_back(rel);
            if (exp_rx.size() == 0) check_eq("rx_extra", rel, -1);
            else check_eq("rx_tick", rel, exp_rx.pop_front());
        end
        if (tx_clk_en) begin
            if (exp_tx.size() == 0) check_eq("tx_extra", rel, -1);
            else check_eq("tx_tick", rel, exp_tx.pop_front());
        end
        if (rx_mid) begin
            if (exp_mid.size() == 0) check_eq("mid_extra", rel, -1);
            else check_eq("mid_tick", rel, exp_mid.pop_front());
        end
    end

    task automatic wait_rel(input int n);
        while (cyc - base < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_win();
        @(posedge clk);
        #1;
        active = 1'b1;
        base   = cyc;
        obs_rx.delete();
    endtask

    task automatic end_win(input string tag, input int n);
        wait_rel(n);
        active = 1'b0;
        #1;
        check_eq({tag, "_rx_left"}, exp_rx.size(), 0);
        check_eq({tag, "_tx_left"}, exp_tx.size(), 0);
        check_eq({tag, "_mid_left"}, exp_mid.size(), 0);
        check_eq({tag, "_idle_out"}, int'({tx_clk_en, rx_clk_en, rx_mid}), 0);
        exp_rx.delete();
        exp_tx.delete();
        exp_mid.delete();
    endtask

    task automatic push_nominal(input int d, input int last);
        for (int t = d - 1; t < last; t += d) exp_rx.push_back(t);
        for (int t = (OS / 2) * d - 1; t < last; t += OS * d) exp_mid.push_back(t);
        for (int t = OS * d - 1; t < last; t += OS * d) exp_tx.push_back(t);
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_frac  = '0;
        #2;
        check_eq("rst_ready", int'(cfg_if.cfg_ready), 1);
        check_eq("rst_err", int'(cfg_if.cfg_err), 0);
        check_eq("rst_outs", int'({tx_clk_en, rx_clk_en, rx_mid}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Nominal timing from reset divisor
        start_win();
        push_nominal(27, 500);
        end_win("nom", 500);

        // rx_sync on a would-be tick cycle, plus a rejected D=1 config
        start_win();
        exp_rx.push_back(26);
        exp_rx.push_back(53);
        exp_rx.push_back(80);
        for (int t = 134; t < 500; t += 27) exp_rx.push_back(t);
        exp_mid.push_back(323);
        exp_tx.push_back(431);
        wait_rel(107);
        rx_sync = 1'b1;
        wait_rel(108);
        rx_sync = 1'b0;
        wait_rel(200);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 16'd1;
        wait_rel(201);
        cfg_if.cfg_valid = 1'b0;
        check_eq("bad_err", int'(cfg_if.cfg_err), 1);
        check_eq("bad_ready", int'(cfg_if.cfg_ready), 1);
        wait_rel(202);
        check_eq("bad_err_once", int'(cfg_if.cfg_err), 0);
        end_win("sync", 500);

        // Runtime change to D=10, applied at the bit boundary
        start_win();
        for (int t = 26; t <= 431; t += 27) exp_rx.push_back(t);
        for (int t = 441; t < 601; t += 10) exp_rx.push_back(t);
        exp_mid.push_back(215);
        exp_mid.push_back(511);
        exp_tx.push_back(431);
        exp_tx.push_back(591);
        wait_rel(100);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 16'd10;
        cfg_if.cfg_frac  = '0;
        wait_rel(101);
        cfg_if.cfg_valid = 1'b0;
        check_eq("d10_busy", int'(cfg_if.cfg_ready), 0);
        wait_rel(431);
        check_eq("d10_busy_edge", int'(cfg_if.cfg_ready), 0);
        wait_rel(432);
        check_eq("d10_done", int'(cfg_if.cfg_ready), 1);
        end_win("d10", 601);

        // Resume, then async reset mid-count restores RESET_DIV
        start_win();
        wait_rel(5);
        arst_n = 1'b0;
        #1;
        check_eq("arst_outs", int'({tx_clk_en, rx_clk_en, rx_mid}), 0);
        check_eq("arst_ready", int'(cfg_if.cfg_ready), 1);
        arst_n = 1'b1;
        base = cyc;
        push_nominal(27, 440);
        end_win("arst", 440);

        // Fractional trim D=27, F=2 programmed while idle
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 16'd27;
        cfg_if.cfg_frac  = 4'd2;
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
        check_eq("frac_pend", int'(cfg_if.cfg_ready), 0);
        @(posedge clk);
        #1;
        check_eq("frac_applied", int'(cfg_if.cfg_ready), 1);
        start_win();
        begin
            int t;
            t = 26;
            for (int k = 1; t < 560; k++) begin
                exp_rx.push_back(t);
                if (k == OS / 2) exp_mid.push_back(t);
                if (k == OS) exp_tx.push_back(t);
                t += 27 + ((FRAC_ON == 1 && (k % 8) == 0) ? 1 : 0);
            end
        end
        end_win("frac", 560);
        if (obs_rx.size() >= 10)
            check_eq("frac_sum8", obs_rx[9] - obs_rx[1], (FRAC_ON == 1) ? 217 : 216);
        else
            check_eq("frac_count", obs_rx.size(), 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
